// File: rtl/pixel_sensor_controller.sv
// pixel_sensor_controller
//   Frame sequencer for the pixel array. One start request runs a full frame:
//   erase -> expose -> ramp conversion -> row readout, then back to idle.
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-low reset
//   start        frame request, sampled only while idle
//   expose_time  exposure length in clk cycles, latched on accepted start (0 acts as 1)
//   all_cmp      every pixel comparator has fired (early end of conversion)
//   ERASE        pixel erase strobe to the array
//   EXPOSE       pixel expose strobe to the array
//   RAMP         ramp step strobe to the array
//   counter      ramp step count to the pixel data latches
//   read_row     one-hot row select during readout, else 0
//   read_valid   readout row presented
//   read_ready   readout consumer accepts current row
//   busy         high from the cycle after an accepted start through frame_done
//   frame_done   one-cycle pulse after the last row is accepted
module pixel_sensor_controller #(
  parameter int PIXEL_BITS   = 8,
  parameter int ERASE_CYCLES = 5,
  parameter int ROWS         = 2,
  parameter int EXPOSE_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [EXPOSE_W-1:0]   expose_time,
  input  logic                  all_cmp,
  output logic                  ERASE,
  output logic                  EXPOSE,
  output logic                  RAMP,
  output logic [PIXEL_BITS-1:0] counter,
  output logic [ROWS-1:0]       read_row,
  output logic                  read_valid,
  input  logic                  read_ready,
  output logic                  busy,
  output logic                  frame_done
);

  // Phase timer shared by the erase and expose phases; wide enough for either.
  localparam int TW = (EXPOSE_W > 32) ? EXPOSE_W : 32;

  typedef enum logic [2:0] {
    IDLE,
    ERASE_ST,
    EXPOSE_ST,
    CONVERT,
    READ
  } state_t;

  state_t                state, state_n;
  logic [TW-1:0]         timer, timer_n;
  logic [EXPOSE_W-1:0]   exposure, exposure_n;
  logic [EXPOSE_W-1:0]   expose_last;
  logic                  erase_n, expose_n, ramp_n;
  logic [PIXEL_BITS-1:0] counter_n;
  logic [ROWS-1:0]       row_n;
  logic                  valid_n, busy_n, done_n;

  assign expose_last = exposure - 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      exposure   <= '0;
      ERASE      <= 1'b0;
      EXPOSE     <= 1'b0;
      RAMP       <= 1'b0;
      counter    <= '0;
      read_row   <= '0;
      read_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      exposure   <= exposure_n;
      ERASE      <= erase_n;
      EXPOSE     <= expose_n;
      RAMP       <= ramp_n;
      counter    <= counter_n;
      read_row   <= row_n;
      read_valid <= valid_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

  // Every output is registered, so each branch computes the value the
  // outputs take in the cycle after the edge, not the current cycle.
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    exposure_n = exposure;
    erase_n    = 1'b0;
    expose_n   = 1'b0;
    ramp_n     = 1'b0;
    counter_n  = counter;
    row_n      = read_row;
    valid_n    = read_valid;
    busy_n     = busy;
    done_n     = 1'b0;

    unique case (state)
      IDLE: begin
        // busy is still high in the frame_done cycle (state already IDLE)
        // and stays high when a back-to-back start is accepted here.
        busy_n = start;
        if (start) begin
          exposure_n = (expose_time == '0) ? EXPOSE_W'(1) : expose_time;
          state_n    = ERASE_ST;
          erase_n    = 1'b1;
          timer_n    = '0;
          counter_n  = '0;
        end
      end

      ERASE_ST: begin
        if (timer == TW'(ERASE_CYCLES - 1)) begin
          state_n  = EXPOSE_ST;
          expose_n = 1'b1;
          timer_n  = '0;
        end else begin
          erase_n = 1'b1;
          timer_n = timer + 1'b1;
        end
      end

      EXPOSE_ST: begin
        if (timer == TW'(expose_last)) begin
          state_n = CONVERT;
        end else begin
          expose_n = 1'b1;
          timer_n  = timer + 1'b1;
        end
      end

      CONVERT: begin
        // all_cmp is honoured only after a RAMP-low cycle; the full-scale
        // check only after a RAMP-high cycle, since that is where counter moves.
        if (!RAMP) begin
          if (all_cmp) begin
            state_n = READ;
            valid_n = 1'b1;
            row_n   = ROWS'(1);
          end else begin
            ramp_n    = 1'b1;
            counter_n = counter + 1'b1;
          end
        end else if (counter == '1) begin
          state_n = READ;
          valid_n = 1'b1;
          row_n   = ROWS'(1);
        end
      end

      READ: begin
        if (read_ready) begin
          if (read_row[ROWS-1]) begin
            state_n = IDLE;
            valid_n = 1'b0;
            row_n   = '0;
            done_n  = 1'b1;
          end else begin
            row_n = read_row << 1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pixel_sensor_controller.sv
// Bench for pixel_sensor_controller. A driver issues frames with randomized
// exposure, comparator timing and readout back-pressure, pushing the expected
// frame outcome (phase lengths, pulse count, total frame length) into a queue.
// A monitor measures each frame from the DUT outputs and compares on frame_done.
module tb_pixel_sensor_controller;

  localparam int PB   = 8;
  localparam int EC   = 2;
  localparam int NR   = 2;
  localparam int EW   = 16;
  localparam int MAXP = (1 << PB) - 1;

  logic          clk = 1'b0;
  logic          reset, start, all_cmp, read_ready;
  logic [EW-1:0] expose_time;
  logic          ERASE, EXPOSE, RAMP, read_valid, busy, frame_done;
  logic [PB-1:0] counter;
  logic [NR-1:0] read_row;

  pixel_sensor_controller #(
    .PIXEL_BITS  (PB),
    .ERASE_CYCLES(EC),
    .ROWS        (NR),
    .EXPOSE_W    (EW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .expose_time(expose_time),
    .all_cmp    (all_cmp),
    .ERASE      (ERASE),
    .EXPOSE     (EXPOSE),
    .RAMP       (RAMP),
    .counter    (counter),
    .read_row   (read_row),
    .read_valid (read_valid),
    .read_ready (read_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int erase;
    int expose;
    int pulses;
    int len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int id, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s frame %0d got %0d expected %0d", name, id, got, exp_v);
    end
  endtask

  function automatic int outs();
    return int'({ERASE, EXPOSE, RAMP, counter, read_row, read_valid, busy, frame_done});
  endfunction

  // ---------------- monitor ----------------
  bit          in_frame = 0;
  bit          prev_stall = 0;
  logic [NR-1:0] prev_row;
  int jcnt, erase_c, expose_c, ramp_c, acc;
  int busy_err = 0, excl_err = 0, cnt_err = 0, stall_err = 0, row_err = 0;

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_frame   = 0;
        prev_stall = 0;
      end else begin
        if (ERASE && !in_frame) begin
          in_frame = 1;
          jcnt = 0; erase_c = 0; expose_c = 0; ramp_c = 0; acc = 0;
        end
        if (busy !== in_frame) busy_err++;
        if (int'(ERASE) + int'(EXPOSE) + int'(RAMP) > 1) excl_err++;
        if (in_frame) begin
          if (ERASE) begin
            erase_c++;
            if (counter != '0) cnt_err++;
          end
          if (EXPOSE) expose_c++;
          if (RAMP) begin
            ramp_c++;
            if (int'(counter) != ramp_c) cnt_err++;
          end
        end
        if (prev_stall && (!read_valid || read_row != prev_row)) stall_err++;
        if (!read_valid && read_row != '0) row_err++;
        if (read_valid && read_ready) begin
          if (int'(read_row) != (1 << acc)) row_err++;
          acc++;
        end
        prev_stall = read_valid && !read_ready;
        prev_row   = read_row;
        if (frame_done) begin
          if (!in_frame || sb.size() == 0) begin
            chk("unexpected_frame_done", -1, 1, 0);
          end else begin
            x = sb.pop_front();
            chk("erase_cycles",  x.id, erase_c,      x.erase);
            chk("expose_cycles", x.id, expose_c,     x.expose);
            chk("ramp_pulses",   x.id, ramp_c,       x.pulses);
            chk("final_counter", x.id, int'(counter), x.pulses);
            chk("frame_len",     x.id, jcnt,         x.len);
            chk("rows_accepted", x.id, acc,          NR);
            chk("busy_track",    x.id, busy_err,     0);
            chk("strobe_excl",   x.id, excl_err,     0);
            chk("counter_track", x.id, cnt_err,      0);
            chk("row_stall",     x.id, stall_err,    0);
            chk("row_order",     x.id, row_err,      0);
            busy_err = 0; excl_err = 0; cnt_err = 0; stall_err = 0; row_err = 0;
          end
          in_frame = 0;
        end else if (in_frame) begin
          jcnt++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1 with the DUT idle. Frame cycle j counts from the
  // cycle after the accepting edge; convert cycle index c = j - (EC + exposure).
  task automatic run_frame(input int id, input int e, input int cmp_c, input int rmode,
                           input bit hold, input bit extra, input bit abort);
    int   ee, j0, pulses, conv, jr, klast, pj, ones;
    bit   rdy[$];
    exp_t x;
    ee = (e == 0) ? 1 : e;
    j0 = EC + ee;
    // Low convert cycles sit at even indices; by index 2i, i pulses are out.
    if (cmp_c < 0 || (cmp_c + 1) / 2 >= MAXP) begin
      pulses = MAXP;
      conv   = 2 * MAXP;
    end else begin
      pulses = (cmp_c + 1) / 2;
      conv   = 2 * pulses + 1;
    end
    jr   = j0 + conv;
    ones = 0;
    while (ones < NR) begin
      bit b;
      case (rmode)
        0:       b = 1'b1;
        1:       b = 1'($urandom_range(1, 0));
        default: b = (rdy.size() >= 4);
      endcase
      rdy.push_back(b);
      if (b) ones++;
    end
    klast = rdy.size() - 1;
    pj    = $urandom_range(jr - 1, 1);

    start       = 1'b1;
    expose_time = EW'(e);
    @(posedge clk); #1;
    if (!abort) begin
      x = '{id: id, erase: EC, expose: ee, pulses: pulses, len: jr + klast + 1};
      sb.push_back(x);
    end
    for (int j = 0; ; j++) begin
      start       = hold || (extra && j == pj);
      expose_time = EW'($urandom);
      if (j < j0 || j >= jr) all_cmp = 1'($urandom_range(1, 0));
      else                   all_cmp = (cmp_c >= 0 && j - j0 >= cmp_c);
      read_ready = (j >= jr) ? rdy[j - jr] : 1'($urandom_range(1, 0));
      if (abort && j == j0 + 20) begin
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_abort", id, outs(), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_release_idle", id, outs(), 0);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      if (j == jr + klast) break;
    end
    start      = hold;
    all_cmp    = 1'b0;
    read_ready = 1'b0;
  endtask

  task automatic frame(input int id, input int e, input int cmp_c, input int rmode,
                       input bit hold, input bit extra, input bit abort);
    run_frame(id, e, cmp_c, rmode, hold, extra, abort);
    if (!hold) begin
      start = 1'b0;
      repeat ($urandom_range(3, 0)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    int e, c;
    reset       = 1'b0;
    start       = 1'b0;
    all_cmp     = 1'b0;
    read_ready  = 1'b0;
    expose_time = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_init", 0, outs(), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    frame(1, 3, -1, 0, 1'b0, 1'b0, 1'b0);   // full-scale conversion
    frame(2, 2, 19, 0, 1'b0, 1'b0, 1'b0);   // early end at counter 10
    frame(3, 4, 7, 2, 1'b0, 1'b0, 1'b0);    // 4-cycle readout stall
    frame(4, 0, 30, 0, 1'b0, 1'b1, 1'b0);   // zero exposure, stray start
    frame(5, 1, -1, 0, 1'b0, 1'b0, 1'b1);   // reset mid-conversion
    frame(6, 5, 508, 1, 1'b0, 1'b0, 1'b0);  // one pulse short of full scale
    frame(7, 1, 509, 0, 1'b0, 1'b0, 1'b0);  // comparator lands on full scale
    frame(8, 2, 4, 1, 1'b1, 1'b0, 1'b0);    // start held: back-to-back
    frame(9, 3, 11, 0, 1'b1, 1'b0, 1'b0);
    frame(10, 0, 0, 1, 1'b1, 1'b0, 1'b0);
    for (int i = 11; i < 27; i++) begin
      e = $urandom_range(7, 0);
      case ($urandom_range(7, 0))
        0:       c = -1;
        1:       c = $urandom_range(512, 505);
        default: c = $urandom_range(40, 0);
      endcase
      frame(i, e, c, $urandom_range(2, 0), 1'($urandom_range(1, 0)),
            1'($urandom_range(1, 0)), 1'b0);
    end
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pending_frames", 0, sb.size(), 0);
    chk("idle_busy_track", 0, busy_err + excl_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
